// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-stage types: per-lane payload structs, widths, occupancy encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    localparam int XLEN      = 32;
    localparam int CTRL_W    = 32;
    localparam int MAX_LANES = 4;

    // Control plus operand data carried from decode into execute, one per lane.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
    } decode_exec_t;

    localparam int DECODE_EXEC_W = $bits(decode_exec_t);

    // Number of bundles held by a stage; the value doubles as the FSM state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_bundle_slot.sv
// One bundle register: LANES valid bits plus the flat lane payload.
// Latency: load/clear/squash take effect on the next rising edge.
// Backpressure: none; the owner decides when to load.
module pipe_bundle_slot
    import riscv_pipe_pkg::*;
#(
    parameter int LANES         = 2,
    parameter int PAYLOAD_W     = DECODE_EXEC_W,
    parameter bit RESET_PAYLOAD = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_load,
    input  logic [LANES-1:0]           i_load_valid,
    input  logic [LANES*PAYLOAD_W-1:0] i_load_payload,
    input  logic [LANES-1:0]           i_squash,
    output logic [LANES-1:0]           o_valid,
    output logic [LANES*PAYLOAD_W-1:0] o_payload
);

    logic [LANES-1:0]           r_valid;
    logic [LANES*PAYLOAD_W-1:0] r_payload;

    // Valid bits: clear beats load beats squash write-back.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= '0;
        end else if (i_load) begin
            r_valid <= i_load_valid;
        end else begin
            r_valid <= r_valid & ~i_squash;
        end
    end

    // Payload: only zeroed on clear when the stage is built to scrub data.
    always_ff @(posedge clk) begin
        if ((rst || i_clear) && RESET_PAYLOAD) begin
            r_payload <= '0;
        end else if (i_load && !(rst || i_clear)) begin
            r_payload <= i_load_payload;
        end
    end

    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule

// File: rtl/multi_issue_pipe_stage.sv
// N-lane inter-stage register with per-lane valids, 2-entry skid, flush and per-lane squash.
// Latency: 1 cycle from accept to presentation when the stage was empty.
// Backpressure: in_ready is registered, low only while both entries are held.
module multi_issue_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int LANES         = 2,
    parameter int PAYLOAD_W     = DECODE_EXEC_W,
    parameter bit RESET_PAYLOAD = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*PAYLOAD_W-1:0] out_payload,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic [LANES-1:0]           squash,
    output logic [1:0]                 occupancy
);

    occ_e r_state;
    occ_e w_nxt_state;
    logic r_in_ready;

    logic [LANES-1:0]           w_main_valid;
    logic [LANES*PAYLOAD_W-1:0] w_main_payload;
    logic [LANES-1:0]           w_skid_valid;
    logic [LANES*PAYLOAD_W-1:0] w_skid_payload;

    logic                       w_present;
    logic [LANES-1:0]           w_main_sq;
    logic                       w_in_fire;
    logic                       w_out_fire;
    logic                       w_consume;
    logic                       w_clear;
    logic                       w_main_load;
    logic                       w_main_from_skid;
    logic                       w_skid_load;
    logic [LANES-1:0]           w_main_ld_valid;
    logic [LANES*PAYLOAD_W-1:0] w_main_ld_payload;
    logic [LANES-1:0]           w_main_squash;

    // Squash acts on the presented bundle only; an empty stage has nothing to kill.
    assign w_present     = (r_state != OCC_EMPTY);
    assign w_main_sq     = w_main_valid & ~squash;
    assign w_main_squash = w_present ? squash : '0;
    assign out_valid     = w_present ? w_main_sq : '0;
    assign out_payload   = w_main_payload;
    assign w_in_fire     = (|in_valid) && r_in_ready;
    assign w_out_fire    = (|out_valid) && out_ready;
    // A bundle squashed down to no valid lanes leaves just as if it had been taken.
    assign w_consume     = w_present && (w_out_fire || !(|w_main_sq));

    assign w_main_ld_valid   = w_main_from_skid ? w_skid_valid   : in_valid;
    assign w_main_ld_payload = w_main_from_skid ? w_skid_payload : in_payload;

    // Next-state and slot control; flush overrides every other event.
    always_comb begin
        w_nxt_state      = r_state;
        w_clear          = 1'b0;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            w_nxt_state = OCC_EMPTY;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_in_fire) begin
                        w_nxt_state = OCC_ONE;
                        w_main_load = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_in_fire && w_consume) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_nxt_state = OCC_TWO;
                        w_skid_load = 1'b1;
                    end else if (w_consume) begin
                        w_nxt_state = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_consume) begin
                        w_nxt_state      = OCC_ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = OCC_EMPTY;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    // State register; reset dominates flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_nxt_state != OCC_TWO);
        end
    end

    assign in_ready  = r_in_ready;
    assign occupancy = r_state;

    pipe_bundle_slot #(
        .LANES         (LANES),
        .PAYLOAD_W     (PAYLOAD_W),
        .RESET_PAYLOAD (RESET_PAYLOAD)
    ) u_main (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (w_clear),
        .i_load         (w_main_load),
        .i_load_valid   (w_main_ld_valid),
        .i_load_payload (w_main_ld_payload),
        .i_squash       (w_main_squash),
        .o_valid        (w_main_valid),
        .o_payload      (w_main_payload)
    );

    pipe_bundle_slot #(
        .LANES         (LANES),
        .PAYLOAD_W     (PAYLOAD_W),
        .RESET_PAYLOAD (RESET_PAYLOAD)
    ) u_skid (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (w_clear),
        .i_load         (w_skid_load),
        .i_load_valid   (in_valid),
        .i_load_payload (in_payload),
        .i_squash       ('0),
        .o_valid        (w_skid_valid),
        .o_payload      (w_skid_payload)
    );

endmodule

// File: tb/tb_multi_issue_pipe_stage.sv
// Bench for multi_issue_pipe_stage at LANES=1,2,4 against a bounded-queue reference model.
// Latency: n/a.
// Backpressure: driver holds each bundle until the model reports it accepted.
module tb_multi_issue_pipe_stage;
    import riscv_pipe_pkg::*;

    localparam int W  = DECODE_EXEC_W;
    localparam int ML = 4;
    localparam int PW = ML * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    iv  [3];
    logic [PW-1:0] ip  [3];
    logic          orr [3];
    logic          fl  [3];
    logic [3:0]    sq  [3];

    logic [3:0]    ov  [3];
    logic [PW-1:0] op  [3];
    logic          ir  [3];
    logic [1:0]    oc  [3];

    logic [0:0]     ov1;
    logic [1:0]     ov2;
    logic [3:0]     ov4;
    logic [W-1:0]   op1;
    logic [2*W-1:0] op2;
    logic [4*W-1:0] op4;
    logic           ir1, ir2, ir4;
    logic [1:0]     oc1, oc2, oc4;

    always_comb begin
        ov[0] = {3'b000, ov1};
        ov[1] = {2'b00, ov2};
        ov[2] = ov4;
        op[0] = PW'(op1);
        op[1] = PW'(op2);
        op[2] = op4;
        ir[0] = ir1;
        ir[1] = ir2;
        ir[2] = ir4;
        oc[0] = oc1;
        oc[1] = oc2;
        oc[2] = oc4;
    end

    multi_issue_pipe_stage #(.LANES(1), .PAYLOAD_W(W), .RESET_PAYLOAD(1'b1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(iv[0][0:0]), .in_payload(ip[0][W-1:0]),
        .in_ready(ir1), .out_valid(ov1), .out_payload(op1), .out_ready(orr[0]),
        .flush(fl[0]), .squash(sq[0][0:0]), .occupancy(oc1));

    multi_issue_pipe_stage #(.LANES(2), .PAYLOAD_W(W), .RESET_PAYLOAD(1'b1)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(iv[1][1:0]), .in_payload(ip[1][2*W-1:0]),
        .in_ready(ir2), .out_valid(ov2), .out_payload(op2), .out_ready(orr[1]),
        .flush(fl[1]), .squash(sq[1][1:0]), .occupancy(oc2));

    multi_issue_pipe_stage #(.LANES(4), .PAYLOAD_W(W), .RESET_PAYLOAD(1'b1)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_payload(ip[2]),
        .in_ready(ir4), .out_valid(ov4), .out_payload(op4), .out_ready(orr[2]),
        .flush(fl[2]), .squash(sq[2]), .occupancy(oc4));

    // Reference model: each instance is an ordered list of at most two bundles.
    typedef struct packed {
        logic [3:0]    v;
        logic [PW-1:0] p;
    } bnd_t;

    bnd_t m_ent  [3][2];
    int   m_cnt  [3];
    bit   m_zero [3];
    bit   fired  [3];
    int   n_dout [3];
    bit   chk_en;
    int   n_chk;
    int   n_fail;

    logic [3:0] t_m, t_eov, t_iv, t_sq;

    function automatic int lanes(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [3:0] msk(int k);
        return 4'((1 << lanes(k)) - 1);
    endfunction

    function automatic logic [PW-1:0] rnd();
        logic [PW-1:0] r;
        for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lanes=%0d actual=%0h required=%0h", nm, lanes(k), act, exp);
        end
    endtask

    // Monitor: compare what each DUT presents with the model, then advance the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            t_m = msk(k);
            if (chk_en) begin
                t_eov = (m_cnt[k] > 0) ? (m_ent[k][0].v & ~sq[k] & t_m) : 4'b0000;
                chk("out_valid", k, PW'(ov[k]), PW'(t_eov));
                chk("in_ready", k, PW'(ir[k]), PW'(m_cnt[k] < 2));
                chk("occupancy", k, PW'(oc[k]), PW'(m_cnt[k]));
                for (int l = 0; l < lanes(k); l++) begin
                    if (t_eov[l]) chk("payload_lane", k, PW'(op[k][l*W +: W]), PW'(m_ent[k][0].p[l*W +: W]));
                end
                if (m_zero[k] && m_cnt[k] == 0) chk("payload_cleared", k, op[k], '0);
                if ((|ov[k]) && orr[k]) n_dout[k]++;
            end
            if (rst || fl[k]) begin
                m_cnt[k]  = 0;
                m_zero[k] = 1'b1;
                fired[k]  = 1'b0;
            end else begin
                t_iv     = iv[k] & t_m;
                t_sq     = sq[k] & t_m;
                fired[k] = (t_iv != 0) && (m_cnt[k] < 2);
                if (m_cnt[k] > 0) begin
                    m_ent[k][0].v = m_ent[k][0].v & ~t_sq;
                    if (m_ent[k][0].v == 0 || orr[k]) begin
                        m_ent[k][0] = m_ent[k][1];
                        m_cnt[k]--;
                    end
                end
                if (fired[k]) begin
                    m_ent[k][m_cnt[k]].v = t_iv;
                    m_ent[k][m_cnt[k]].p = ip[k];
                    m_cnt[k]++;
                    m_zero[k] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k);
        iv[k] = '0; orr[k] = 1'b1; sq[k] = '0; fl[k] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic fill_two(input int k);
        orr[k] = 1'b0;
        iv[k] = msk(k); ip[k] = rnd();
        tick();
        ip[k] = rnd();
        tick();
        iv[k] = '0;
    endtask

    task automatic run_tests(input int k);
        int base;
        logic [3:0] m;
        m = msk(k);

        // Continuous stream, downstream always ready.
        drain(k);
        base = n_dout[k];
        iv[k] = m; ip[k] = rnd();
        repeat (100) begin
            tick();
            if (fired[k]) ip[k] = rnd();
        end
        iv[k] = '0;
        tick();
        chk("stream_count", k, PW'(n_dout[k] - base), PW'(100));

        // Backpressure: two bundles queue up, third waits.
        drain(k);
        base = n_dout[k];
        orr[k] = 1'b0;
        iv[k] = m; ip[k] = rnd();
        tick();
        chk("bp_occ1", k, PW'(oc[k]), PW'(1));
        ip[k] = rnd();
        tick();
        chk("bp_occ2", k, PW'(oc[k]), PW'(2));
        chk("bp_rdy0", k, PW'(ir[k]), PW'(0));
        iv[k] = '0;
        tick();
        chk("bp_occ2_hold", k, PW'(oc[k]), PW'(2));
        orr[k] = 1'b1;
        repeat (3) tick();
        chk("bp_count", k, PW'(n_dout[k] - base), PW'(2));

        // Bubble lane: lane 1 carries junk but is never valid.
        if (lanes(k) >= 2) begin
            drain(k);
            iv[k] = 4'b0001; ip[k] = rnd();
            ip[k][W +: 16] = 16'hDEAD;
            tick();
            chk("bubble_ov", k, PW'(ov[k]), PW'(4'b0001));
            iv[k] = '0;
            repeat (2) tick();
        end

        // Squash: partial kill is combinational; full kill promotes the skid entry.
        drain(k);
        fill_two(k);
        sq[k] = 4'b0010 & m;
        #1;
        chk("squash_partial", k, PW'(ov[k]), PW'(m & ~4'b0010));
        tick();
        sq[k] = m;
        tick();
        sq[k] = '0;
        #1;
        chk("squash_promote_ov", k, PW'(ov[k]), PW'(m));
        chk("squash_promote_occ", k, PW'(oc[k]), PW'(1));
        drain(k);

        // Flush with both entries held and a new bundle offered.
        fill_two(k);
        iv[k] = m; ip[k] = rnd(); fl[k] = 1'b1;
        tick();
        fl[k] = 1'b0; iv[k] = '0;
        chk("flush_ov", k, PW'(ov[k]), PW'(0));
        chk("flush_occ", k, PW'(oc[k]), PW'(0));
        chk("flush_rdy", k, PW'(ir[k]), PW'(1));
        drain(k);

        // Reset while full.
        fill_two(k);
        chk("rst_pre_occ", k, PW'(oc[k]), PW'(2));
        iv[k] = m; rst = 1'b1;
        tick();
        rst = 1'b0; iv[k] = '0;
        chk("rst_ov", k, PW'(ov[k]), PW'(0));
        chk("rst_occ", k, PW'(oc[k]), PW'(0));
        chk("rst_rdy", k, PW'(ir[k]), PW'(1));
        chk("rst_payload", k, op[k], '0);
        drain(k);

        // Random traffic with squash, flush and backpressure.
        for (int c = 0; c < 300; c++) begin
            orr[k] = ($urandom % 4) != 0;
            sq[k]  = (($urandom % 8) == 0) ? (4'($urandom) & m) : 4'b0000;
            fl[k]  = ($urandom % 40) == 0;
            if (iv[k] == 0 || fired[k]) begin
                iv[k] = (($urandom % 4) == 0) ? 4'b0000 : 4'($urandom_range(1, int'(m)));
                ip[k] = rnd();
            end
            tick();
        end
        drain(k);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; chk_en = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; ip[k] = '0; orr[k] = 1'b0; fl[k] = 1'b0; sq[k] = '0;
            m_cnt[k] = 0; m_zero[k] = 1'b1; fired[k] = 1'b0; n_dout[k] = 0;
        end
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ov", k, PW'(ov[k]), PW'(0));
            chk("reset_occ", k, PW'(oc[k]), PW'(0));
            chk("reset_rdy", k, PW'(ir[k]), PW'(1));
            chk("reset_payload", k, op[k], '0);
        end
        run_tests(1);
        run_tests(0);
        run_tests(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
